data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Memory-side responder for the M stage of the pipelined core. Accepts the load/store request presented by the execute/memory pipeline register and serves it from an internal byte-addressable data RAM with a programmable wait-state count. Holds the pipeline via `StallM` until the access completes. Performs byte/half/word lane selection, load sign/zero extension and alignment checking.

## Interface
- `DATA_WIDTH`, default 32: data bus width. Fixed at 32 for this block.
- `ADDR_WIDTH`, default 12: byte-address bits used. The RAM holds 2^ADDR_WIDTH bytes, organised as 32-bit words.
- `WAIT_CYCLES`, default 2: extra latency cycles per access, legal range 0..15.

- `clk`  in  1: the single clock. Rising edge active.
- `rst`  in  1: synchronous, active-low reset.
- `MemReadM`  in  1: load request.
- `MemWriteM`  in  1: store request.
- `ALUResultM`  in  32: byte address. Only bits [ADDR_WIDTH-1:0] are used; upper bits are ignored, so addresses wrap.
- `WriteDataM`  in  32: store data, taken from the low bits.
- `LS_modeM`  in  3: funct3 access size and sign.
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
- `ReadDataM`  out  32: extended load result. Valid while `MemReadyM`=1.
- `MemReadyM`  out  1: single-cycle completion strobe.
- `ErrM`  out  1: access faulted. Qualified by `MemReadyM`.
- `StallM`  out  1: pipeline hold request.

## Operation
- FSM states:
  - IDLE: no access in progress.
  - WAIT: counting wait cycles.
  - RESP: response cycle.
- Request definition: `req = MemReadM | MemWriteM`. The pipeline holds all inputs stable while `StallM`=1.
- IDLE transitions:
  - If `req`, go to WAIT with the counter loaded to WAIT_CYCLES-1.
  - If WAIT_CYCLES=0, go directly to RESP.
- WAIT transitions:
  - Decrement the counter each cycle.
  - Go to RESP in the cycle after the counter reaches 0.
- RESP transitions: always return to IDLE. A new request is first seen in IDLE on the following cycle.
- `StallM` is combinational: `(IDLE & req) | WAIT`. It is 0 in RESP and 0 while `rst`=0.
- Fault conditions, evaluated on the held request:
  - Both `MemReadM` and `MemWriteM` asserted.
  - Load mode in {011, 110, 111}.
  - Store mode other than {000, 001, 010}.
  - Half-word access with addr[0]=1.
  - Word access with addr[1:0]≠0.
- On a fault: no RAM write; `ReadDataM`=0; `ErrM`=1 during the RESP cycle.
- Stores:
  - Byte enables come from addr[1:0] and size: SB one lane, SH lanes {1:0} or {3:2}, SW all four lanes.
  - Data is replicated into the selected lanes.
  - The RAM write is committed at the clock edge that ends RESP. No write occurs if `rst`=0 on that edge.
- Loads:
  - The addressed word is read and the lane selected by addr[1:0].
  - LB/LH sign-extend to 32 bits; LBU/LHU zero-extend.
  - The result is registered into `ReadDataM` on entry to RESP.
- `ReadDataM` holds its value until the next RESP. After a store completes, `ReadDataM` is 0.
- RAM contents are not affected by reset.

## Timing
- Reset values: state IDLE, counter 0, `ReadDataM`=0, `MemReadyM`=0, `ErrM`=0, `StallM`=0.
- Latency:
  - Request first seen in IDLE at cycle t gives `MemReadyM`=1 at cycle t+WAIT_CYCLES+1.
  - `StallM` is high for cycles t .. t+WAIT_CYCLES and low at t+WAIT_CYCLES+1.
- Back-to-back requests: minimum spacing is WAIT_CYCLES+2 cycles, since the RESP→IDLE cycle always intervenes.
- Store followed by a load to the same address: the load returns the new data.
- Reset mid-access, in WAIT or RESP: return to IDLE, drop the access, perform no write, no `MemReadyM` strobe.
- `MemReadyM` and `ErrM` are high only in RESP and are never asserted for more than one cycle.

## Test plan
- WAIT_CYCLES=2: SW 0xDEADBEEF to 0x010, then LW 0x010.
  - `StallM` high for 3 cycles.
  - `MemReadyM` at t+3.
  - `ReadDataM`=0xDEADBEEF.
- SB 0x80 to 0x013, then LB 0x013 and LBU 0x013.
  - LB returns 0xFFFFFF80; LBU returns 0x00000080.
  - Word 0x010 reads 0x80ADBEEF.
- SH 0x1234 to 0x012, then LH 0x012.
  - Returns 0x00001234.
  - LHU 0x011 → `ErrM`=1, `ReadDataM`=0, RAM unchanged.
- SW to 0x006 (misaligned) and LS_modeM=011 load.
  - Both complete with `ErrM`=1.
  - No write: a following LW 0x004 is unchanged.
- Reset asserted in the WAIT cycle of SW 0x55 to 0x020.
  - `MemReadyM` never pulses; `StallM`=0 next cycle.
  - A later LW 0x020 returns the old contents.
- WAIT_CYCLES=0: alternate LW requests held by the pipeline.
  - `MemReadyM` every 2nd cycle; `StallM` high one cycle per access.
  - Address 0x1004 aliases to 0x004.

Source files
------------

// File: rtl/data_mem_responder.sv
// data_mem_responder
//   M-stage memory responder. Serves one load or store at a time from an
//   internal byte-addressable RAM (2^ADDR_WIDTH bytes, 32-bit words) after
//   WAIT_CYCLES extra cycles. Holds the pipeline with StallM until the
//   response cycle. Handles byte/half/word lanes, load extension and
//   alignment faults.
// Ports:
//   clk        - clock, rising edge
//   rst        - synchronous reset, active low
//   MemReadM   - load request
//   MemWriteM  - store request
//   ALUResultM - byte address (upper bits ignored, addresses wrap)
//   WriteDataM - store data (low bits used for SB/SH)
//   LS_modeM   - funct3 access size / signedness
//   ReadDataM  - extended load result, valid while MemReadyM=1
//   MemReadyM  - one-cycle completion strobe
//   ErrM       - access fault, qualified by MemReadyM
//   StallM     - pipeline hold request
module data_mem_responder #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 12,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  MemReadM,
  input  logic                  MemWriteM,
  input  logic [DATA_WIDTH-1:0] ALUResultM,
  input  logic [DATA_WIDTH-1:0] WriteDataM,
  input  logic [2:0]            LS_modeM,
  output logic [DATA_WIDTH-1:0] ReadDataM,
  output logic                  MemReadyM,
  output logic                  ErrM,
  output logic                  StallM
);

  localparam int WA_W  = ADDR_WIDTH - 2;
  localparam int WORDS = 2 ** WA_W;
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                  state, state_nxt;
  logic [3:0]              cnt, cnt_nxt;
  logic                    req;
  logic                    capture;
  logic                    fault;
  logic [WA_W-1:0]         waddr;
  logic [1:0]              boff;
  logic [DATA_WIDTH-1:0]   rd_word;
  logic                    unused_addr_hi;

  logic [DATA_WIDTH-1:0]   mem [WORDS];

  logic                    err_p1;
  logic                    wr_en_p1;
  logic [WA_W-1:0]         wr_addr_p1;
  logic [DATA_WIDTH-1:0]   wr_data_p1;
  logic [3:0]              be_p1;

  function automatic logic [31:0] load_extend(input logic [2:0] mode,
                                              input logic [31:0] word,
                                              input logic [1:0] off);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] r;
    b = word[{off, 3'b000} +: 8];
    h = word[{off[1], 4'b0000} +: 16];
    case (mode)
      3'b000:  r = 32'(b);
      3'b001:  r = 32'(h);
      3'b100:  r = {24'd0, b};
      3'b101:  r = {16'd0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  function automatic logic access_fault(input logic rd, input logic wr,
                                        input logic [2:0] mode,
                                        input logic [1:0] off);
    logic f;
    if (rd && wr)
      f = 1'b1;
    else if (rd)
      f = !(mode inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    else
      f = !(mode inside {3'b000, 3'b001, 3'b010});
    if (mode[1:0] == 2'b01 && off[0])
      f = 1'b1;
    if (mode[1:0] == 2'b10 && off != 2'b00)
      f = 1'b1;
    return f;
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] mode, input logic [1:0] off);
    logic [3:0] be;
    case (mode[1:0])
      2'b00:   be = 4'b0001 << off;
      2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] mode, input logic [31:0] wd);
    logic [31:0] d;
    case (mode[1:0])
      2'b00:   d = {4{wd[7:0]}};
      2'b01:   d = {2{wd[15:0]}};
      default: d = wd;
    endcase
    return d;
  endfunction

  assign req            = MemReadM | MemWriteM;
  assign waddr          = ALUResultM[ADDR_WIDTH-1:2];
  assign boff           = ALUResultM[1:0];
  assign unused_addr_hi = ^ALUResultM[DATA_WIDTH-1:ADDR_WIDTH];
  assign rd_word        = mem[waddr];
  assign fault          = access_fault(MemReadM, MemWriteM, LS_modeM, boff);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    StallM    = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          StallM = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_nxt = RESP;
            capture   = 1'b1;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        StallM = 1'b1;
        if (cnt == 4'd0) begin
          state_nxt = RESP;
          capture   = 1'b1;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // Reset overrides the held request so the pipeline is never stalled in reset.
    if (!rst)
      StallM = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      ReadDataM <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (capture)
        ReadDataM <= (MemReadM && !fault) ? load_extend(LS_modeM, rd_word, boff) : '0;
    end
  end

  // ---- p1: request captured on entry to RESP (inputs may change during RESP)
  always_ff @(posedge clk) begin
    if (capture) begin
      err_p1     <= fault;
      wr_en_p1   <= MemWriteM && !fault;
      wr_addr_p1 <= waddr;
      wr_data_p1 <= store_data(LS_modeM, WriteDataM);
      be_p1      <= store_be(LS_modeM, boff);
    end
  end

  assign MemReadyM = (state == RESP) && rst;
  assign ErrM      = MemReadyM && err_p1;

  // ---- RAM commit at the edge ending RESP; suppressed if reset is asserted
  always_ff @(posedge clk) begin
    if (rst && state == RESP && wr_en_p1) begin
      for (int i = 0; i < 4; i++) begin
        if (be_p1[i])
          mem[wr_addr_p1][8*i +: 8] <= wr_data_p1[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder
//   Directed bench for data_mem_responder. Instance u2 uses WAIT_CYCLES=2,
//   instance u0 uses WAIT_CYCLES=0; both share clk and rst. Inputs change
//   and outputs are sampled around the falling edge.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        rd2 = 1'b0, wr2 = 1'b0;
  logic [31:0] addr2 = '0, wd2 = '0;
  logic [2:0]  mode2 = '0;
  logic [31:0] rdata2;
  logic        rdy2, err2, stall2;

  logic        rd0 = 1'b0, wr0 = 1'b0;
  logic [31:0] addr0 = '0, wd0 = '0;
  logic [2:0]  mode0 = '0;
  logic [31:0] rdata0;
  logic        rdy0, err0, stall0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .WAIT_CYCLES(2)) u2 (
    .clk(clk), .rst(rst), .MemReadM(rd2), .MemWriteM(wr2), .ALUResultM(addr2),
    .WriteDataM(wd2), .LS_modeM(mode2), .ReadDataM(rdata2), .MemReadyM(rdy2),
    .ErrM(err2), .StallM(stall2));

  data_mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .WAIT_CYCLES(0)) u0 (
    .clk(clk), .rst(rst), .MemReadM(rd0), .MemWriteM(wr0), .ALUResultM(addr0),
    .WriteDataM(wd0), .LS_modeM(mode0), .ReadDataM(rdata0), .MemReadyM(rdy0),
    .ErrM(err0), .StallM(stall0));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input bit w0, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] d, input logic [2:0] m);
    if (w0) begin
      rd0 = rd; wr0 = wr; addr0 = a; wd0 = d; mode0 = m;
    end else begin
      rd2 = rd; wr2 = wr; addr2 = a; wd2 = d; mode2 = m;
    end
  endtask

  // Issue one request at a falling edge (DUT idle), hold it until MemReadyM,
  // then drop it and step to the next falling edge.
  task automatic access(input bit w0, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] d, input logic [2:0] m,
                        output logic [31:0] rdata, output logic err,
                        output int stalls, output int lat);
    lat = -1; stalls = 0; rdata = '0; err = 1'b0;
    set_req(w0, rd, wr, a, d, m);
    for (int n = 0; n < 20; n++) begin
      #1;
      if (w0 ? stall0 : stall2) stalls++;
      if (w0 ? rdy0 : rdy2) begin
        lat   = n;
        rdata = w0 ? rdata0 : rdata2;
        err   = w0 ? err0 : err2;
        break;
      end
      @(negedge clk);
    end
    set_req(w0, 1'b0, 1'b0, '0, '0, 3'b000);
    @(negedge clk);
  endtask

  task automatic check_access(input string tag, input bit w0, input logic rd, input logic wr,
                              input logic [31:0] a, input logic [31:0] d, input logic [2:0] m,
                              input logic [31:0] exp_data, input logic exp_err, input int exp_lat);
    logic [31:0] rdata;
    logic        err;
    int          stalls, lat;
    access(w0, rd, wr, a, d, m, rdata, err, stalls, lat);
    chk({tag, ".lat"},   32'(lat),    32'(exp_lat));
    chk({tag, ".stall"}, 32'(stalls), 32'(exp_lat));
    chk({tag, ".err"},   32'(err),    32'(exp_err));
    chk({tag, ".data"},  rdata,       exp_data);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;

    // Reset with a request pending: stall must stay low.
    rd2 = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst.data",  rdata2, 32'h0);
    chk("rst.ready", 32'(rdy2), 32'h0);
    chk("rst.err",   32'(err2), 32'h0);
    chk("rst.stall", 32'(stall2), 32'h0);
    chk("rst.data0", rdata0, 32'h0);
    rd2 = 1'b0;
    rst = 1'b1;
    @(negedge clk);

    // Word store / load round trip
    check_access("sw10",  1'b0, 1'b0, 1'b1, 32'h010, 32'hDEADBEEF, 3'b010, 32'h0, 1'b0, 3);
    check_access("lw10",  1'b0, 1'b1, 1'b0, 32'h010, 32'h0, 3'b010, 32'hDEADBEEF, 1'b0, 3);

    // Byte store, signed / unsigned byte loads
    check_access("sb13",  1'b0, 1'b0, 1'b1, 32'h013, 32'h00000080, 3'b000, 32'h0, 1'b0, 3);
    check_access("lb13",  1'b0, 1'b1, 1'b0, 32'h013, 32'h0, 3'b000, 32'hFFFFFF80, 1'b0, 3);
    check_access("lbu13", 1'b0, 1'b1, 1'b0, 32'h013, 32'h0, 3'b100, 32'h00000080, 1'b0, 3);
    check_access("lw10b", 1'b0, 1'b1, 1'b0, 32'h010, 32'h0, 3'b010, 32'h80ADBEEF, 1'b0, 3);

    // Half store / load, misaligned half load
    check_access("sh12",  1'b0, 1'b0, 1'b1, 32'h012, 32'h00001234, 3'b001, 32'h0, 1'b0, 3);
    check_access("lh12",  1'b0, 1'b1, 1'b0, 32'h012, 32'h0, 3'b001, 32'h00001234, 1'b0, 3);
    check_access("lhu11", 1'b0, 1'b1, 1'b0, 32'h011, 32'h0, 3'b101, 32'h0, 1'b1, 3);
    #1;
    chk("lhu11.errdrop", 32'(err2), 32'h0);
    chk("lhu11.rdydrop", 32'(rdy2), 32'h0);
    @(negedge clk);
    check_access("lw10c", 1'b0, 1'b1, 1'b0, 32'h010, 32'h0, 3'b010, 32'h1234BEEF, 1'b0, 3);

    // Faulting accesses leave RAM untouched
    check_access("sw04",  1'b0, 1'b0, 1'b1, 32'h004, 32'h01020304, 3'b010, 32'h0, 1'b0, 3);
    check_access("sw06",  1'b0, 1'b0, 1'b1, 32'h006, 32'hFFFFFFFF, 3'b010, 32'h0, 1'b1, 3);
    check_access("ld011", 1'b0, 1'b1, 1'b0, 32'h004, 32'h0, 3'b011, 32'h0, 1'b1, 3);
    check_access("rdwr",  1'b0, 1'b1, 1'b1, 32'h004, 32'hFFFFFFFF, 3'b010, 32'h0, 1'b1, 3);
    check_access("sbbad", 1'b0, 1'b0, 1'b1, 32'h004, 32'hFFFFFFFF, 3'b100, 32'h0, 1'b1, 3);
    check_access("lw04",  1'b0, 1'b1, 1'b0, 32'h004, 32'h0, 3'b010, 32'h01020304, 1'b0, 3);

    // Reset in the WAIT cycle of a store drops it
    check_access("sw20",  1'b0, 1'b0, 1'b1, 32'h020, 32'h11223344, 3'b010, 32'h0, 1'b0, 3);
    set_req(1'b0, 1'b0, 1'b1, 32'h020, 32'h00000055, 3'b010);
    #1;
    chk("rstw.stall_req", 32'(stall2), 32'h1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rstw.stall_in_rst", 32'(stall2), 32'h0);
    chk("rstw.ready_in_rst", 32'(rdy2), 32'h0);
    @(negedge clk);
    #1;
    chk("rstw.stall_next", 32'(stall2), 32'h0);
    set_req(1'b0, 1'b0, 1'b0, '0, '0, 3'b000);
    rst = 1'b1;
    @(negedge clk);
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (rdy2) pulses++;
      @(negedge clk);
    end
    chk("rstw.pulses", 32'(pulses), 32'h0);
    check_access("lw20",  1'b0, 1'b1, 1'b0, 32'h020, 32'h0, 3'b010, 32'h11223344, 1'b0, 3);

    // Zero wait states, aliasing, request held continuously
    check_access("z.sw04", 1'b1, 1'b0, 1'b1, 32'h004, 32'hCAFEF00D, 3'b010, 32'h0, 1'b0, 1);
    check_access("z.lw04", 1'b1, 1'b1, 1'b0, 32'h004, 32'h0, 3'b010, 32'hCAFEF00D, 1'b0, 1);
    set_req(1'b1, 1'b1, 1'b0, 32'h1004, 32'h0, 3'b010);
    for (int i = 0; i < 6; i++) begin
      #1;
      chk($sformatf("z.held%0d.ready", i), 32'(rdy0),   32'(i % 2));
      chk($sformatf("z.held%0d.stall", i), 32'(stall0), 32'((i + 1) % 2));
      if (i % 2 == 1)
        chk($sformatf("z.held%0d.data", i), rdata0, 32'hCAFEF00D);
      @(negedge clk);
    end
    set_req(1'b1, 1'b0, 1'b0, '0, '0, 3'b000);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
